// File: rtl/memory_line_bridge_pkg.sv
// Shared types and helpers for the cache-line to word-beat memory bridge.
package memory_line_bridge_pkg;

  typedef enum logic [1:0] {
    BRIDGE_IDLE,
    BRIDGE_WRITE,
    BRIDGE_READ,
    BRIDGE_DONE
  } bridge_state_t;

  // Number of backing-bus beats that make up one cache line.
  function automatic int beat_count(input int line_size, input int beat_size);
    return line_size / beat_size;
  endfunction

endpackage

// File: rtl/memory_interface.sv
// Cache-line request/response channel between the arbiter (initiator) and memory (responder).
interface memory_interface #(
  parameter int LINE_SIZE = 256,
  parameter int ADDR_SIZE = 32
) ();

  logic [ADDR_SIZE-1:0] addr;
  logic                 write;
  logic                 valid;
  logic [LINE_SIZE-1:0] wr_data;
  logic [LINE_SIZE-1:0] rd_data;
  logic                 ready;

  modport responder (
    input  addr, write, valid, wr_data,
    output rd_data, ready
  );

  modport initiator (
    output addr, write, valid, wr_data,
    input  rd_data, ready
  );

endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage viewed as BEATS words: full-line load, single-beat write, beat read mux.
module line_beat_buffer #(
  parameter int LINE_SIZE = 256,
  parameter int BEAT_SIZE = 32,
  parameter int IDX_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [LINE_SIZE-1:0] line_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [BEAT_SIZE-1:0] wr_data_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [BEAT_SIZE-1:0] rd_beat_o,
  output logic [LINE_SIZE-1:0] line_o
);

  localparam int BEATS = LINE_SIZE / BEAT_SIZE;

  logic [BEATS-1:0][BEAT_SIZE-1:0] line_q, line_d;

  // Indices at or beyond BEATS select nothing; the counters reach BEATS on the final beat.
  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else if (wr_en_i) begin
      for (int b = 0; b < BEATS; b++) begin
        if (wr_idx_i == IDX_W'(b)) line_d[b] = wr_data_i;
      end
    end
  end

  always_comb begin
    rd_beat_o = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (rd_idx_i == IDX_W'(b)) rd_beat_o = line_q[b];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) line_q <= '0;
    else          line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/memory_line_bridge.sv
// Responder for cache-line requests: splits each line into word beats on a req/gnt bus
// with pipelined, in-order read returns, and reassembles read beats into the line.
module memory_line_bridge
  import memory_line_bridge_pkg::*;
#(
  parameter int LINE_SIZE = 256,
  parameter int ADDR_SIZE = 32,
  parameter int BEAT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  memory_interface.responder   memory_bus,
  output logic                 ext_req_o,
  output logic                 ext_we_o,
  output logic [ADDR_SIZE-1:0] ext_addr_o,
  output logic [BEAT_SIZE-1:0] ext_wdata_o,
  input  logic                 ext_gnt_i,
  input  logic                 ext_rvalid_i,
  input  logic [BEAT_SIZE-1:0] ext_rdata_i
);

  localparam int BEATS      = beat_count(LINE_SIZE, BEAT_SIZE);
  localparam int BEAT_BYTES = BEAT_SIZE / 8;
  localparam int LINE_BYTES = LINE_SIZE / 8;
  localparam int CNT_W      = $clog2(BEATS) + 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(BEATS);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(LINE_BYTES - 1);

  bridge_state_t        state_q, state_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]     recv_cnt_q, recv_cnt_d;

  logic                 buf_load;
  logic                 buf_wr_en;
  logic [BEAT_SIZE-1:0] buf_beat;
  logic [LINE_SIZE-1:0] buf_line;
  logic                 req;

  line_beat_buffer #(
    .LINE_SIZE (LINE_SIZE),
    .BEAT_SIZE (BEAT_SIZE),
    .IDX_W     (CNT_W)
  ) u_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (buf_load),
    .line_i    (memory_bus.wr_data),
    .wr_en_i   (buf_wr_en),
    .wr_idx_i  (recv_cnt_q),
    .wr_data_i (ext_rdata_i),
    .rd_idx_i  (issue_cnt_q),
    .rd_beat_o (buf_beat),
    .line_o    (buf_line)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    buf_load    = 1'b0;
    buf_wr_en   = 1'b0;
    case (state_q)
      BRIDGE_IDLE: begin
        if (memory_bus.valid) begin
          buf_load    = 1'b1;
          base_d      = memory_bus.addr & ~OFF_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = memory_bus.write ? BRIDGE_WRITE : BRIDGE_READ;
        end
      end
      BRIDGE_WRITE: begin
        if (ext_gnt_i) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == CNT_LAST) state_d = BRIDGE_DONE;
        end
      end
      BRIDGE_READ: begin
        // Issue and return run independently; completion is driven by the last return only.
        if (issue_cnt_q < CNT_FULL && ext_gnt_i) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (ext_rvalid_i) begin
          buf_wr_en  = 1'b1;
          recv_cnt_d = recv_cnt_q + CNT_W'(1);
          if (recv_cnt_q == CNT_LAST) state_d = BRIDGE_DONE;
        end
      end
      BRIDGE_DONE: state_d = BRIDGE_IDLE;
      default:     state_d = BRIDGE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= BRIDGE_IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // Outputs decode registered state only, so they hold steady while gnt is low.
  always_comb begin
    req         = (state_q == BRIDGE_WRITE) ||
                  (state_q == BRIDGE_READ && issue_cnt_q < CNT_FULL);
    ext_req_o   = req;
    ext_we_o    = (state_q == BRIDGE_WRITE);
    ext_addr_o  = req ? base_q + ADDR_SIZE'(issue_cnt_q) * ADDR_SIZE'(BEAT_BYTES) : '0;
    ext_wdata_o = (state_q == BRIDGE_WRITE) ? buf_beat : '0;
  end

  assign memory_bus.ready   = (state_q == BRIDGE_DONE);
  assign memory_bus.rd_data = buf_line;

endmodule
